// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs,
// ALU operation codes, datapath mux selects and the FSM state set.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REXE   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_BNE    = 4'd9,
    ST_JUMP   = 4'd10,
    ST_JAL    = 4'd11,
    ST_JR     = 4'd12,
    ST_IEXE   = 4'd13,
    ST_IWB    = 4'd14
  } mcState_t;

  // What the current state needs from the ALU; FUNC/IMM defer to the instruction bits.
  typedef enum logic [2:0] {
    ALU_CLS_NONE = 3'd0,
    ALU_CLS_ADD  = 3'd1,
    ALU_CLS_SUB  = 3'd2,
    ALU_CLS_FUNC = 3'd3,
    ALU_CLS_IMM  = 3'd4
  } aluClass_t;

  function automatic logic isRtypeAluFunc(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_alu_control.sv
// Combinational ALU-operation decode from the state's ALU class plus the
// instruction's opcode/func fields.
module mc_alu_control
  import mc_pkg::*;
(
  input  aluClass_t   aluClass,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic [2:0]  aluOperation
);

  logic [2:0] funcOp;
  logic [2:0] immOp;

  always_comb begin
    funcOp = ALU_ADD;
    case (func)
      FN_ADD:  funcOp = ALU_ADD;
      FN_SUB:  funcOp = ALU_SUB;
      FN_AND:  funcOp = ALU_AND;
      FN_OR:   funcOp = ALU_OR;
      FN_SLT:  funcOp = ALU_SLT;
      default: funcOp = ALU_ADD;
    endcase
  end

  always_comb begin
    immOp = ALU_ADD;
    case (opcode)
      OP_ADDI: immOp = ALU_ADD;
      OP_SLTI: immOp = ALU_SLT;
      OP_ANDI: immOp = ALU_AND;
      default: immOp = ALU_ADD;
    endcase
  end

  always_comb begin
    aluOperation = 3'b000;
    case (aluClass)
      ALU_CLS_ADD:  aluOperation = ALU_ADD;
      ALU_CLS_SUB:  aluOperation = ALU_SUB;
      ALU_CLS_FUNC: aluOperation = funcOp;
      ALU_CLS_IMM:  aluOperation = immOp;
      default:      aluOperation = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM, one state per cycle, driving
// all datapath strobes. Every output is held at 0 while rst is high.
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic [2:0]  AluOperation,
  output logic [1:0]  PCSrc,
  output logic [1:0]  AluSrcB,
  output logic        AluSrcA,
  output logic        RegDst,
  output logic        link,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemToReg,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        branch,
  output logic        illegal
);

  mcState_t  stateReg;
  mcState_t  stateNext;
  aluClass_t aluClass;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= ST_FETCH;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext   = ST_FETCH;
    aluClass    = ALU_CLS_NONE;
    PCSrc       = 2'b00;
    AluSrcB     = 2'b00;
    AluSrcA     = 1'b0;
    RegDst      = 1'b0;
    link        = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    MemToReg    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;

    case (stateReg)
      ST_FETCH: begin
        MemRead   = 1'b1;
        IRWrite   = 1'b1;
        AluSrcB   = SRCB_FOUR;
        aluClass  = ALU_CLS_ADD;
        PCSrc     = PC_ALU;
        PCWrite   = 1'b1;
        stateNext = ST_DECODE;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        AluSrcB  = SRCB_IMMSH;
        aluClass = ALU_CLS_ADD;
        case (opcode)
          OP_LW, OP_SW:               stateNext = ST_MEMADR;
          OP_BEQ:                     stateNext = ST_BEQ;
          OP_BNE:                     stateNext = ST_BNE;
          OP_J:                       stateNext = ST_JUMP;
          OP_JAL:                     stateNext = ST_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI:  stateNext = ST_IEXE;
          OP_RTYPE: begin
            if (func == FN_JR) begin
              stateNext = ST_JR;
            end else if (isRtypeAluFunc(func)) begin
              stateNext = ST_REXE;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        AluSrcA   = 1'b1;
        AluSrcB   = SRCB_IMM;
        aluClass  = ALU_CLS_ADD;
        stateNext = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        stateNext = ST_MEMWB;
      end
      ST_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_REXE: begin
        AluSrcA   = 1'b1;
        AluSrcB   = SRCB_B;
        aluClass  = ALU_CLS_FUNC;
        stateNext = ST_RWB;
      end
      ST_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        AluSrcA     = 1'b1;
        AluSrcB     = SRCB_B;
        aluClass    = ALU_CLS_SUB;
        PCWriteCond = 1'b1;
        branch      = (stateReg == ST_BEQ);
        PCSrc       = PC_ALUOUT;
      end
      ST_JUMP: begin
        PCSrc   = PC_JUMP;
        PCWrite = 1'b1;
      end
      ST_JAL: begin
        // PC already holds PC+4, which the register file captures as the link value.
        PCSrc    = PC_JUMP;
        PCWrite  = 1'b1;
        link     = 1'b1;
        RegWrite = 1'b1;
      end
      ST_JR: begin
        PCSrc   = PC_REGA;
        PCWrite = 1'b1;
      end
      ST_IEXE: begin
        AluSrcA   = 1'b1;
        AluSrcB   = SRCB_IMM;
        aluClass  = ALU_CLS_IMM;
        stateNext = ST_IWB;
      end
      ST_IWB: begin
        RegWrite = 1'b1;
      end
      default: begin
        stateNext = ST_FETCH;
      end
    endcase

    if (rst) begin
      aluClass    = ALU_CLS_NONE;
      PCSrc       = 2'b00;
      AluSrcB     = 2'b00;
      AluSrcA     = 1'b0;
      RegDst      = 1'b0;
      link        = 1'b0;
      RegWrite    = 1'b0;
      IRWrite     = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      MemToReg    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      branch      = 1'b0;
      illegal     = 1'b0;
    end
  end

  mc_alu_control aluCtrl (
    .aluClass     (aluClass),
    .opcode       (opcode),
    .func         (func),
    .aluOperation (AluOperation)
  );

endmodule
